// File: rtl/subtractor_32bit_serial.sv
// Slice-serial subtractor: diff = a - b, one SLICE-bit slice per clock, LSB slice first,
// with the borrow rippled between slices through a register. Valid/ready on both sides,
// one operation in flight.
module subtractor_32bit_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);

    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic              bor_q, bor_d;
    logic              borrow_q, borrow_d;
    logic              ovf_q, ovf_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [SLICE:0]    slice_res;
    logic [WIDTH+SLICE-1:0] diff_shift;

    // Current slice: operands are shifted down each cycle, so the active slice is always
    // the low SLICE bits; results enter diff from the top and shift down into place.
    always_comb begin
        slice_res  = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, bor_q};
        diff_shift = {slice_res[SLICE-1:0], diff_q} >> SLICE;
    end

    // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bor_d    = bor_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    bor_d   = 1'b0;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                diff_d = diff_shift[WIDTH-1:0];
                a_d    = a_q >> SLICE;
                b_d    = b_q >> SLICE;
                bor_d  = slice_res[SLICE];
                idx_d  = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    borrow_d = slice_res[SLICE];
                    // Top bit of the last slice is the final diff MSB.
                    ovf_d    = (a_msb_q != b_msb_q) && (slice_res[SLICE-1] != a_msb_q);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bor_q    <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bor_q    <= bor_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs are pure state decodes or registers.
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        diff_o      = diff_q;
        borrow_o    = borrow_q;
        ovf_o       = ovf_q;
    end

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
// Bench for subtractor_32bit_serial: directed corner cases, backpressure, async reset
// mid-operation, and randomized back-to-back traffic against an arithmetic reference.
module tb_subtractor_32bit_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;

    int n_vec;
    int n_err;

    subtractor_32bit_serial #(
        .WIDTH(32),
        .SLICE(8)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .diff_o     (diff),
        .borrow_o   (borrow),
        .ovf_o      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, borrow, diff} from plain arithmetic.
    function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        logic        br;
        logic        ov;
        d  = x - y;
        br = (x < y);
        ov = (x[31] != y[31]) && (d[31] != x[31]);
        return {ov, br, d};
    endfunction

    // One operation: accept, check latency and result, optionally stall, then handshake.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ed,
                          input logic eb, input logic eo, input int stall);
        int   lat;
        logic seen;
        @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            seen = out_valid;
        end
        check("latency", lat, 4);
        @(negedge clk);
        check("diff", diff, ed);
        check("borrow", borrow, eb);
        check("ovf", ovf, eo);
        check("ready_in_done", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a        = $urandom;
            b        = $urandom;
            check("stall_valid", out_valid, 1);
            check("stall_diff", diff, ed);
            check("stall_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
    endtask

    initial begin
        logic [33:0] exp_q[$];
        logic [33:0] e;
        logic        stale;
        int          issued;
        int          done;
        int          prev;
        int          cycles;

        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        rst_n     = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h12345678, 32'h02345678, 32'h10000000, 1'b0, 1'b0, 0);
        run_op(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run_op(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 0);
        // Backpressure: result must hold for 10 cycles while new operands wiggle.
        run_op(32'hDEADBEEF, 32'h0BADF00D, 32'hD2FFCEE2, 1'b0, 1'b0, 10);

        // Async reset two cycles into an operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hCAFEF00D;
        b        = 32'h00001234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_borrow", borrow, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_result", stale, 0);
        run_op(32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 0);

        // 100 random back-to-back operations with the sink always ready.
        out_ready = 1'b1;
        issued    = 0;
        done      = 0;
        prev      = 0;
        cycles    = 0;
        while (done < 100 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_diff", diff, e[31:0]);
                    check("rnd_borrow", borrow, e[32]);
                    check("rnd_ovf", ovf, e[33]);
                    done++;
                end
            end
            if (in_ready) begin
                if (issued < 100) begin
                    a        = $urandom;
                    b        = $urandom;
                    in_valid = 1'b1;
                    exp_q.push_back(ref_sub(a, b));
                    if (issued > 0) check("accept_spacing", cycles - prev, 6);
                    prev = cycles;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("rnd_results", done, 100);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
